game_menu_ctrl: RTL and testbench

GAME_MENU_CTRL -- requirements
Module: game_menu_ctrl

---
 rtl/game_menu_ctrl_if.sv | 27 ++
 rtl/game_menu_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_menu_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/game_menu_ctrl_if.sv
// Player-facing signal bundle for the game menu controller.
// confirm_valid is a one-cycle strobe with no ready; song_confirm is meaningful only while it is high.
interface game_menu_ctrl_if #(
  parameter int NUM_BTN   = 3,
  parameter int NUM_SONGS = 3
);
  localparam int SW = $clog2(NUM_SONGS + 1);

  logic [NUM_BTN-1:0] btn;
  logic               finish;
  logic [2:0]         state;
  logic [SW-1:0]      song_select;
  logic [SW-1:0]      active_song;
  logic               confirm_valid;
  logic [SW-1:0]      song_confirm;
  logic [NUM_BTN-1:0] btn_pulse;

  modport slave (
    input  btn, finish,
    output state, song_select, active_song, confirm_valid, song_confirm, btn_pulse
  );

  modport master (
    output btn, finish,
    input  state, song_select, active_song, confirm_valid, song_confirm, btn_pulse
  );
endinterface

// File: rtl/game_menu_ctrl.sv
// Song menu controller: synchronised, debounced buttons drive a START/MENU/PLAY/PAUSE/FINISH FSM
// with wrap-around song selection and an idle return from MENU to START.
module game_menu_ctrl #(
  parameter int NUM_BTN      = 3,
  parameter int NUM_SONGS    = 3,
  parameter int DEB_CYCLES   = 4,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  game_menu_ctrl_if.slave  bus_if
);
  localparam int SW = $clog2(NUM_SONGS + 1);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_MENU   = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSE  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  logic [NUM_BTN-1:0] sync1_q, sync2_q, deb_q, deb_dly_q, pulse_q;
  logic [DW-1:0]      cnt_q [NUM_BTN];

  state_e        state_q, state_d;
  logic [SW-1:0] song_q, song_d;
  logic [SW-1:0] active_q, active_d;
  logic          cv_q, cv_d;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  logic          prev_p, next_p, conf_p, any_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus_if.btn;
      sync2_q <= sync1_q;
    end
  end

  // The debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
            deb_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_dly_q <= '0;
      pulse_q   <= '0;
    end else begin
      deb_dly_q <= deb_q;
      pulse_q   <= deb_q & ~deb_dly_q;
    end
  end

  assign prev_p   = pulse_q[0];
  assign next_p   = pulse_q[1];
  assign conf_p   = pulse_q[2];
  assign any_p    = |pulse_q;
  assign idle_inc = (idle_q == IW'(IDLE_TIMEOUT)) ? idle_q : idle_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    active_d = active_q;
    cv_d     = 1'b0;
    idle_d   = idle_q;
    case (state_q)
      S_START: if (any_p) state_d = S_MENU;
      S_MENU: begin
        if (conf_p) begin
          state_d  = S_PLAY;
          active_d = song_q;
          cv_d     = 1'b1;
        end else if (any_p) begin
          idle_d = '0;
          if (prev_p && !next_p)
            song_d = (song_q == SW'(1)) ? SW'(NUM_SONGS) : song_q - 1'b1;
          else if (next_p && !prev_p)
            song_d = (song_q == SW'(NUM_SONGS)) ? SW'(1) : song_q + 1'b1;
        end else begin
          idle_d = idle_inc;
          if (idle_inc == IW'(IDLE_TIMEOUT)) begin
            state_d = S_START;
            song_d  = SW'(1);
          end
        end
      end
      S_PLAY: begin
        if (bus_if.finish) state_d = S_FINISH;
        else if (conf_p)   state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (conf_p) begin
          state_d = S_PLAY;
        end else if (prev_p) begin
          state_d  = S_MENU;
          active_d = '0;
        end
      end
      S_FINISH: begin
        if (conf_p) begin
          state_d  = S_MENU;
          active_d = '0;
        end
      end
      default: state_d = S_START;
    endcase
    if (state_d == S_MENU && state_q != S_MENU) idle_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_START;
      song_q   <= SW'(1);
      active_q <= '0;
      cv_q     <= 1'b0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      active_q <= active_d;
      cv_q     <= cv_d;
      idle_q   <= idle_d;
    end
  end

  assign bus_if.state         = state_q;
  assign bus_if.song_select   = song_q;
  assign bus_if.active_song   = active_q;
  assign bus_if.confirm_valid = cv_q;
  assign bus_if.song_confirm  = cv_q ? active_q : '0;
  assign bus_if.btn_pulse     = pulse_q;
endmodule

// File: tb/tb_game_menu_ctrl.sv
// Directed bench for game_menu_ctrl: latency, glitch rejection, menu navigation, play/pause/finish, idle and reset.
module tb_game_menu_ctrl;
  localparam int NB = 4;
  localparam int NS = 3;
  localparam int DC = 4;
  localparam int IT = 16;
  localparam int SW = $clog2(NS + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  game_menu_ctrl_if #(.NUM_BTN(NB), .NUM_SONGS(NS)) bus ();

  game_menu_ctrl #(
    .NUM_BTN(NB), .NUM_SONGS(NS), .DEB_CYCLES(DC), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt [NB];
  logic [SW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: every confirm strobe must match the next expected locked song
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) if (bus.btn_pulse[i]) pulse_cnt[i]++;
    if (bus.confirm_valid) begin
      if (exp_q.size() == 0) check_eq("cv_unexpected", 1, 0);
      else check_eq("song_confirm", bus.song_confirm, exp_q.pop_front());
    end
  end

  // driver: raw press for 4 edges, release, let the release settle; returns at a negedge
  task automatic press(input logic [NB-1:0] m);
    @(negedge clk) bus.btn = m;
    repeat (4) @(posedge clk);
    @(negedge clk) bus.btn = '0;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"},  bus.state, 0);
    check_eq({tag, "_song"},   bus.song_select, 1);
    check_eq({tag, "_active"}, bus.active_song, 0);
    check_eq({tag, "_cv"},     bus.confirm_valid, 0);
    check_eq({tag, "_sc"},     bus.song_confirm, 0);
    check_eq({tag, "_pulse"},  bus.btn_pulse, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.btn = '0;
    bus.finish = 1'b0;
    #23;
    check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    // short glitch on next in START
    @(negedge clk) bus.btn = 4'b0010;
    repeat (2) @(posedge clk);
    @(negedge clk) bus.btn = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_pulses", pulse_cnt[1], 0);
    check_eq("glitch_state", bus.state, 0);

    // wake-only button held 10 cycles: exact latency
    @(negedge clk) bus.btn = 4'b1000;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk) check_eq("lat_pulse_e5", bus.btn_pulse, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_pulse_e6", bus.btn_pulse, 4'b1000);
    check_eq("lat_state_e6", bus.state, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("lat_state_e7", bus.state, 1);
    check_eq("lat_pulse_e7", bus.btn_pulse, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) bus.btn = '0;

    // navigation with wrap and simultaneous prev+next
    press(4'b0001);
    check_eq("nav_prev_wrap", bus.song_select, 3);
    press(4'b0010);
    check_eq("nav_next_wrap", bus.song_select, 1);
    press(4'b0010);
    check_eq("nav_next", bus.song_select, 2);
    press(4'b0011);
    check_eq("nav_both", bus.song_select, 2);
    check_eq("nav_state", bus.state, 1);
    check_eq("wake_pulses", pulse_cnt[3], 1);

    // confirm locks song 2
    exp_q.push_back(SW'(2));
    press(4'b0100);
    check_eq("conf_state", bus.state, 2);
    check_eq("conf_active", bus.active_song, 2);
    check_eq("conf_cv_after", bus.confirm_valid, 0);
    check_eq("conf_sc_after", bus.song_confirm, 0);
    check_eq("conf_seen", exp_q.size(), 0);

    // pause, finish ignored, prev back to menu
    press(4'b0100);
    check_eq("pause_state", bus.state, 3);
    @(negedge clk) bus.finish = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("pause_finish", bus.state, 3);
    bus.finish = 1'b0;
    press(4'b0001);
    check_eq("pause_prev_state", bus.state, 1);
    check_eq("pause_prev_active", bus.active_song, 0);
    check_eq("pause_prev_song", bus.song_select, 2);

    // idle timeout: menu entered 4 edges before press() returned
    repeat (11) @(posedge clk);
    @(negedge clk) check_eq("idle_before", bus.state, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_state", bus.state, 0);
    check_eq("idle_song", bus.song_select, 1);

    // START -> MENU -> PLAY -> FINISH -> MENU -> PLAY
    press(4'b0100);
    check_eq("wake_conf_state", bus.state, 1);
    exp_q.push_back(SW'(1));
    press(4'b0100);
    check_eq("play2_state", bus.state, 2);
    @(negedge clk) bus.finish = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("finish_state", bus.state, 4);
    bus.finish = 1'b0;
    press(4'b0100);
    check_eq("finish_menu_state", bus.state, 1);
    check_eq("finish_menu_active", bus.active_song, 0);
    exp_q.push_back(SW'(1));
    press(4'b0100);
    check_eq("play3_state", bus.state, 2);
    check_eq("play3_active", bus.active_song, 1);

    // asynchronous reset mid-PLAY, with confirm held through release
    #2 rst_n = 1'b0;
    bus.btn = 4'b0100;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk) check_eq("hold_e6", bus.btn_pulse, 0);
    @(posedge clk);
    @(negedge clk) check_eq("hold_e7", bus.btn_pulse, 4'b0100);
    @(posedge clk);
    @(negedge clk) check_eq("hold_state", bus.state, 1);
    bus.btn = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
